// File: rtl/led_ctrl.sv
// Register-mapped LED controller: DATA/SET/CLR/TOGGLE plus per-channel blink with a 24-bit prescaler.
// Latency WAIT_STATES+1 cycles to a one-cycle ready pulse; requester holds sel until ready, dropping it aborts.
module led_ctrl #(
  parameter int          NUM_LEDS    = 6,
  parameter int          WAIT_STATES = 15,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter logic [31:0] RESET_VAL   = 32'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                we,
  input  logic [2:0]          addr,
  input  logic [31:0]         wdata,
  output logic                ready,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] leds_o
);

  localparam logic [3:0]          WS       = 4'(WAIT_STATES);
  localparam logic [NUM_LEDS-1:0] POL      = {NUM_LEDS{ACTIVE_LOW}};
  localparam logic [NUM_LEDS-1:0] RST_DATA = RESET_VAL[NUM_LEDS-1:0];

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state;
  logic [3:0]          count;
  logic [NUM_LEDS-1:0] data;
  logic [NUM_LEDS-1:0] blink_en;
  logic [23:0]         blink_div;
  logic [23:0]         blink_cnt;
  logic                phase;

  logic                commit;
  logic                wr_div;
  logic [NUM_LEDS-1:0] wval;
  logic [31:0]         rval;
  logic                unused_wdata;

  // commit is true on exactly the edge that moves the FSM into DONE
  assign commit       = sel && ((state == IDLE && WS == 4'd0) || (state == WAIT && count == WS));
  assign wr_div       = commit && we && (addr == 3'd5);
  assign wval         = wdata[NUM_LEDS-1:0];
  assign unused_wdata = ^wdata;

  always_comb begin
    rval = '0;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: rval[NUM_LEDS-1:0] = data;
      3'd4:                   rval[NUM_LEDS-1:0] = blink_en;
      3'd5:                   rval[23:0]         = blink_div;
      default:                rval               = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (sel) begin
            if (WS == 4'd0) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              state <= WAIT;
              count <= 4'd1;
            end
          end
        end
        WAIT: begin
          if (!sel) begin
            state <= IDLE;
            count <= 4'd0;
          end else if (count == WS) begin
            state <= DONE;
            ready <= 1'b1;
            count <= 4'd0;
          end else begin
            count <= count + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit) rdata <= we ? 32'd0 : rval;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= RST_DATA;
      blink_en  <= '0;
      blink_div <= 24'd0;
    end else if (commit && we) begin
      case (addr)
        3'd0:    data      <= wval;
        3'd1:    data      <= data | wval;
        3'd2:    data      <= data & ~wval;
        3'd3:    data      <= data ^ wval;
        3'd4:    blink_en  <= wval;
        3'd5:    blink_div <= wdata[23:0];
        default: ;
      endcase
    end
  end

  // A divider write restarts the blink period from phase 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= 24'd0;
      phase     <= 1'b0;
    end else if (wr_div) begin
      blink_cnt <= wdata[23:0];
      phase     <= 1'b0;
    end else if (blink_div != 24'd0) begin
      if (blink_cnt == 24'd0) begin
        blink_cnt <= blink_div;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt - 24'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) leds_o <= RST_DATA ^ POL;
    else       leds_o <= (data ^ (blink_en & {NUM_LEDS{phase}})) ^ POL;
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: default instance (6 LEDs, 15 wait states, active-low) and a 32-LED zero-wait instance.
module tb_led_ctrl;

  logic        clk;
  logic        reset;
  logic        sel, we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [5:0]  leds;

  logic        sel2, we2;
  logic [2:0]  addr2;
  logic [31:0] wdata2;
  logic        ready2;
  logic [31:0] rdata2;
  logic [31:0] leds2;

  int npass = 0;
  int ntotal = 0;

  led_ctrl dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .leds_o(leds)
  );

  led_ctrl #(.NUM_LEDS(32), .WAIT_STATES(0), .ACTIVE_LOW(1'b0), .RESET_VAL(32'd0)) dut32 (
    .clk(clk), .reset(reset), .sel(sel2), .we(we2), .addr(addr2), .wdata(wdata2),
    .ready(ready2), .rdata(rdata2), .leds_o(leds2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [5:0]  exp_leds;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after ready has fallen again.
  task automatic acc(input bit d32, input logic w, input logic [2:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output logic rdy_after);
    if (d32) begin sel2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; end
    else     begin sel  = 1'b1; we  = w; addr  = a; wdata  = d; end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(d32 ? ready2 : ready) && lat < 40);
    rd = d32 ? rdata2 : rdata;
    if (d32) sel2 = 1'b0; else sel = 1'b0;
    @(negedge clk);
    rdy_after = d32 ? ready2 : ready;
  endtask

  logic [31:0] rd;
  int          lat;
  logic        ra;
  int          seen;

  initial begin
    reset = 1'b1;
    sel = 0; we = 0; addr = 0; wdata = 0;
    sel2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;

    vq.push_back('{1'b1, 3'd0, 32'h0000_002A, 32'h0, 6'h15});
    vq.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_002A, 6'h15});
    vq.push_back('{1'b1, 3'd0, 32'h0000_000F, 32'h0, 6'h30});
    vq.push_back('{1'b1, 3'd1, 32'h0000_0030, 32'h0, 6'h00});
    vq.push_back('{1'b1, 3'd2, 32'h0000_0003, 32'h0, 6'h03});
    vq.push_back('{1'b1, 3'd3, 32'h0000_0021, 32'h0, 6'h22});
    vq.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b0, 3'd1, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b0, 3'd2, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b0, 3'd3, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b0, 3'd6, 32'h0,         32'h0,         6'h22});
    vq.push_back('{1'b0, 3'd7, 32'h0,         32'h0,         6'h22});
    vq.push_back('{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0, 6'h22});
    vq.push_back('{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 6'h22});
    vq.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b1, 3'd1, 32'h0,         32'h0, 6'h22});
    vq.push_back('{1'b1, 3'd2, 32'h0,         32'h0, 6'h22});
    vq.push_back('{1'b1, 3'd3, 32'h0,         32'h0, 6'h22});
    vq.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_001D, 6'h22});
    vq.push_back('{1'b1, 3'd0, 32'hFFFF_FFC5, 32'h0, 6'h3A});
    vq.push_back('{1'b0, 3'd0, 32'h0,         32'h0000_0005, 6'h3A});
    vq.push_back('{1'b1, 3'd5, 32'hABCD_EF12, 32'h0, 6'h3A});
    vq.push_back('{1'b0, 3'd5, 32'h0,         32'h00CD_EF12, 6'h3A});
    vq.push_back('{1'b1, 3'd5, 32'h0,         32'h0, 6'h3A});
    vq.push_back('{1'b0, 3'd5, 32'h0,         32'h0,         6'h3A});
    vq.push_back('{1'b1, 3'd4, 32'hFFFF_FFC1, 32'h0, 6'h3A});
    vq.push_back('{1'b0, 3'd4, 32'h0,         32'h0000_0001, 6'h3A});
    vq.push_back('{1'b1, 3'd4, 32'h0,         32'h0, 6'h3A});

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_leds", {26'd0, leds}, 32'h3F);
    chk("rst_leds32", leds2, 32'd0);
    chk("rst_rdata32", rdata2, 32'd0);
    reset = 1'b0;

    // Table-driven register accesses on the default instance
    for (int i = 0; i < vq.size(); i++) begin
      acc(1'b0, vq[i].we, vq[i].addr, vq[i].wdata, rd, lat, ra);
      chk($sformatf("v%0d_latency", i), lat, 32'd16);
      chk($sformatf("v%0d_ready_width", i), {31'd0, ra}, 32'd0);
      chk($sformatf("v%0d_leds", i), {26'd0, leds}, {26'd0, vq[i].exp_leds});
      if (!vq[i].we) chk($sformatf("v%0d_rdata", i), rd, vq[i].exp_rd);
    end

    // Blink LED0 with divider 3: four cycles per phase
    acc(1'b0, 1'b1, 3'd0, 32'h0, rd, lat, ra);
    chk("blk_data0_leds", {26'd0, leds}, 32'h3F);
    acc(1'b0, 1'b1, 3'd4, 32'h1, rd, lat, ra);
    acc(1'b0, 1'b1, 3'd5, 32'h3, rd, lat, ra);
    for (int m = 1; m <= 16; m++) begin
      chk($sformatf("blink_m%0d", m), {26'd0, leds}, (((m - 1) / 4) % 2) ? 32'h3E : 32'h3F);
      @(negedge clk);
    end
    acc(1'b0, 1'b1, 3'd5, 32'h0, rd, lat, ra);
    seen = 0;
    for (int m = 0; m < 12; m++) begin
      if (leds !== 6'h3F) seen++;
      @(negedge clk);
    end
    chk("blink_frozen", seen, 32'd0);
    acc(1'b0, 1'b1, 3'd4, 32'h0, rd, lat, ra);

    // Abort by dropping sel at count 5
    sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h3F;
    seen = 0;
    repeat (5) begin @(negedge clk); if (ready) seen++; end
    sel = 1'b0;
    repeat (20) begin @(negedge clk); if (ready) seen++; end
    chk("abort_no_ready", seen, 32'd0);
    chk("abort_leds", {26'd0, leds}, 32'h3F);
    acc(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, ra);
    chk("abort_data", rd, 32'd0);
    acc(1'b0, 1'b1, 3'd0, 32'h0A, rd, lat, ra);
    chk("post_abort_lat", lat, 32'd16);
    chk("post_abort_leds", {26'd0, leds}, 32'h35);

    // Reset in the middle of a write's wait phase
    sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 32'h3F;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_leds", {26'd0, leds}, 32'h3F);
    sel = 1'b0;
    @(negedge clk);
    chk("midrst_leds_held", {26'd0, leds}, 32'h3F);
    reset = 1'b0;
    acc(1'b0, 1'b0, 3'd0, 32'h0, rd, lat, ra);
    chk("postrst_first_lat", lat, 32'd16);
    chk("postrst_data", rd, 32'd0);

    // Zero-wait, 32-LED, active-high instance
    acc(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, rd, lat, ra);
    chk("w32_lat", lat, 32'd1);
    chk("w32_ready_width", {31'd0, ra}, 32'd0);
    chk("w32_leds", leds2, 32'hFFFF_FFFF);
    acc(1'b1, 1'b0, 3'd0, 32'h0, rd, lat, ra);
    chk("r32_lat", lat, 32'd1);
    chk("r32_data", rd, 32'hFFFF_FFFF);
    acc(1'b1, 1'b1, 3'd2, 32'h0000_FF00, rd, lat, ra);
    acc(1'b1, 1'b0, 3'd1, 32'h0, rd, lat, ra);
    chk("r32_clr", rd, 32'hFFFF_00FF);
    chk("w32_leds_clr", leds2, 32'hFFFF_00FF);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/led_ctrl.md
LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 6, meaning number of LED channels (1..32).
REQ-002 SHALL have parameter WAIT_STATES, default 15, meaning extra cycles before ready (0..15).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning pad polarity (1 = inverted pads).
REQ-004 SHALL have parameter RESET_VAL, default 0, meaning DATA register value after reset.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port sel, input, 1, meaning access request, held until ready.
REQ-008 SHALL have port we, input, 1, meaning write (1) or read (0), valid with sel.
REQ-009 SHALL have port addr, input, 3, meaning word register offset.
REQ-010 SHALL have port wdata, input, 32, meaning write data, low NUM_LEDS bits used except BLINK_DIV.
REQ-011 SHALL have port ready, output, 1, meaning one-cycle access-complete pulse.
REQ-012 SHALL have port rdata, output, 32, meaning read data, valid while ready=1.
REQ-013 SHALL have port leds_o, output, NUM_LEDS, meaning LED pad drive.

Function
REQ-014 Register map SHALL be: 0 DATA rw; 1 SET w1s; 2 CLR w1c; 3 TOGGLE w1t; 4 BLINK_EN rw mask; 5 BLINK_DIV rw 24-bit.
REQ-015 Reads of SET/CLR/TOGGLE SHALL return DATA; reads of 6,7 SHALL return 0; writes to 6,7 SHALL be ignored but still complete with ready.
REQ-016 Unused upper rdata bits SHALL read 0; writes SHALL ignore unused wdata bits.
REQ-017 Access FSM SHALL have states IDLE, WAIT, DONE.
REQ-018 IDLE: sel=1 -> DONE if WAIT_STATES=0, else WAIT with count=1; sel=0 -> stay.
REQ-019 WAIT: sel=1 and count=WAIT_STATES -> DONE; sel=1 otherwise -> count+1; sel=0 -> IDLE, no register effect (abort).
REQ-020 DONE: ready=1 for exactly one cycle, then unconditionally -> IDLE.
REQ-021 Latency SHALL be WAIT_STATES+1 cycles from first sampled sel to ready high.
REQ-022 Write effect and rdata capture SHALL occur on the edge entering DONE, using addr/we/wdata sampled at that edge.
REQ-023 Back-to-back access SHALL need sel sampled in IDLE; minimum spacing WAIT_STATES+2 cycles.
REQ-024 Blink prescaler SHALL be a 24-bit down-counter: at 0, reload BLINK_DIV and toggle phase; otherwise decrement.
REQ-025 BLINK_DIV=0 SHALL freeze counter and phase.
REQ-026 A write to BLINK_DIV SHALL load the counter with the new value and clear phase on the same edge.
REQ-027 Logical LED value SHALL be DATA XOR (BLINK_EN AND {NUM_LEDS{phase}}).
REQ-028 leds_o SHALL be the logical value, inverted when ACTIVE_LOW=1; registered, one cycle after DATA/phase change.
REQ-029 Register write coinciding with phase toggle SHALL apply both: new DATA and new phase.
REQ-030 SET/CLR/TOGGLE with wdata=0 SHALL leave DATA unchanged.

Reset
REQ-031 Asserting reset SHALL immediately force: FSM IDLE, count 0, ready 0, rdata 0, DATA=RESET_VAL, BLINK_EN 0, BLINK_DIV 0, counter 0, phase 0.
REQ-032 During reset leds_o SHALL equal RESET_VAL, inverted if ACTIVE_LOW=1 (default: 6'b111111).
REQ-033 Reset mid-access SHALL abort it with no register effect and no ready pulse.
REQ-034 First access SHALL be accepted on the first clock edge after reset deasserts.

Verification
REQ-035 Default params: write DATA=0x2A -> ready exactly 16 cycles after sel, one cycle wide; leds_o=6'b010101 next cycle.
REQ-036 DATA=0x0F, SET 0x30, CLR 0x03, TOGGLE 0x21 -> DATA reads 0x1D; read addr 6 -> 0, ready pulses.
REQ-037 BLINK_EN=0x01, BLINK_DIV=3 -> LED0 toggles every 4 cycles, other channels static; BLINK_DIV=0 -> phase frozen.
REQ-038 sel dropped in WAIT at count 5 -> no ready, DATA unchanged; next access completes normally.
REQ-039 Reset asserted mid-WAIT of write 0x3F -> immediate ready=0, DATA=RESET_VAL, leds_o all 1.
REQ-040 WAIT_STATES=0, NUM_LEDS=32, ACTIVE_LOW=0 -> ready 1 cycle after sel; write 0xFFFFFFFF reads back 0xFFFFFFFF.
